// File: rtl/decode_issue_if.sv
// Handshake bundle for decode_issue: IF/ID input, issue register output,
// writeback retire port, flush and the stall counter.
`timescale 1ns/1ps
interface decode_issue_if #(
  parameter int PC_W   = 16,
  parameter int PERF_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_intr;
  logic [PC_W-1:0]   in_pc;
  logic              in_brpredict;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_intr;
  logic [PC_W-1:0]   out_pc;
  logic              out_brpredict;
  logic [3:0]        out_sr1;
  logic [3:0]        out_sr2;
  logic [3:0]        out_dest;
  logic              out_is_load;
  logic              wb_valid;
  logic [2:0]        wb_dest;
  logic              wb_is_load;
  logic              flush;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output in_valid, in_intr, in_pc, in_brpredict, out_ready,
           wb_valid, wb_dest, wb_is_load, flush,
    input  in_ready, out_valid, out_intr, out_pc, out_brpredict,
           out_sr1, out_sr2, out_dest, out_is_load, stall_cnt
  );
  modport slave (
    input  in_valid, in_intr, in_pc, in_brpredict, out_ready,
           wb_valid, wb_dest, wb_is_load, flush,
    output in_ready, out_valid, out_intr, out_pc, out_brpredict,
           out_sr1, out_sr2, out_dest, out_is_load, stall_cnt
  );
endinterface

// File: rtl/decode_issue.sv
// LC-3b decode/issue stage with per-register outstanding-write scoreboard.
// Define DECODE_FWD_EN when execute forwards ALU results (only load-use stalls).
`timescale 1ns/1ps
module decode_issue_ctr #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Simultaneous inc/dec cancel; illegal over/underflow holds the count.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && cnt_q != '1)      cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt_o = cnt_q;

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(dec_i && !inc_i && cnt_q == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(inc_i && !dec_i && cnt_q == '1));
endmodule

module decode_issue #(
  parameter int PC_W   = 16,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_issue_if.slave bus
);
  localparam logic [3:0]       NONE    = 4'b1000;
  localparam logic [CNT_W-1:0] CMAX    = '1;
  localparam logic [CNT_W-1:0] CMAX_M1 = CMAX - 1'b1;

  typedef struct packed {
    logic [15:0]     intr;
    logic [PC_W-1:0] pc;
    logic            bp;
    logic [3:0]      sr1;
    logic [3:0]      sr2;
    logic [3:0]      dest;
    logic            is_load;
  } iss_t;

  localparam iss_t OUT_RST = '{intr: '0, pc: '0, bp: 1'b0, sr1: NONE,
                               sr2: NONE, dest: NONE, is_load: 1'b0};

  iss_t                   id, out_q, out_d;
  logic                   out_valid_q, out_valid_d;
  logic [PERF_W-1:0]      stall_q, stall_d;
  logic [7:0][CNT_W-1:0]  pend, ldp;
  logic [7:0]             inc, dec, inc_ld, dec_ld;
  logic [3:0]             op;
  logic                   h1, h2, hd, hazard, accept, fire;

  always_comb begin
    op         = bus.in_intr[15:12];
    id         = OUT_RST;
    id.intr    = bus.in_intr;
    id.pc      = bus.in_pc;
    id.bp      = bus.in_brpredict;
    case (op)
      4'b0001, 4'b0101: begin                 // ADD, AND
        id.sr1  = {1'b0, bus.in_intr[8:6]};
        id.dest = {1'b0, bus.in_intr[11:9]};
        if (!bus.in_intr[5]) id.sr2 = {1'b0, bus.in_intr[2:0]};
      end
      4'b1001, 4'b1101: begin                 // NOT, SHF
        id.sr1  = {1'b0, bus.in_intr[8:6]};
        id.dest = {1'b0, bus.in_intr[11:9]};
      end
      4'b0010, 4'b0110, 4'b1010: begin        // LDB, LDR, LDI
        id.sr1     = {1'b0, bus.in_intr[8:6]};
        id.dest    = {1'b0, bus.in_intr[11:9]};
        id.is_load = 1'b1;
      end
      4'b0011, 4'b0111, 4'b1011: begin        // STB, STR, STI
        id.sr1 = {1'b0, bus.in_intr[8:6]};
        id.sr2 = {1'b0, bus.in_intr[11:9]};
      end
      4'b1100: id.sr1 = {1'b0, bus.in_intr[8:6]};
      4'b0100: begin                          // JSR / JSRR
        id.dest = 4'd7;
        if (!bus.in_intr[11]) id.sr1 = {1'b0, bus.in_intr[8:6]};
      end
      4'b1110: id.dest = {1'b0, bus.in_intr[11:9]};
      4'b1111: id.dest = 4'd7;
      default: ;
    endcase
  end

  always_comb begin
`ifdef DECODE_FWD_EN
    h1 = !id.sr1[3] && (ldp[id.sr1[2:0]] != '0 ||
         (out_valid_q && out_q.is_load && out_q.dest == id.sr1));
    h2 = !id.sr2[3] && (ldp[id.sr2[2:0]] != '0 ||
         (out_valid_q && out_q.is_load && out_q.dest == id.sr2));
`else
    h1 = !id.sr1[3] && (pend[id.sr1[2:0]] != '0 ||
         (out_valid_q && out_q.dest == id.sr1));
    h2 = !id.sr2[3] && (pend[id.sr2[2:0]] != '0 ||
         (out_valid_q && out_q.dest == id.sr2));
`endif
    // Count the writer still sitting in the issue register, otherwise its
    // fire could land on an already saturated counter.
    hd = !id.dest[3] && (pend[id.dest[2:0]] == CMAX ||
         (pend[id.dest[2:0]] == CMAX_M1 && out_valid_q && out_q.dest == id.dest));
    hazard = h1 || h2 || hd;
  end

  assign bus.in_ready = !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign fire         = out_valid_q && bus.out_ready && !bus.flush;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    stall_d     = stall_q;
    if (fire || bus.flush) out_valid_d = 1'b0;
    if (accept) begin
      out_d       = id;
      out_valid_d = 1'b1;
    end
    if (bus.in_valid && hazard && !bus.flush && stall_q != '1)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= OUT_RST;
      stall_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      stall_q     <= stall_d;
    end

  for (genvar r = 0; r < 8; r++) begin : g_reg
    assign inc[r]    = fire && !out_q.dest[3] && out_q.dest[2:0] == 3'(r);
    assign inc_ld[r] = inc[r] && out_q.is_load;
    assign dec[r]    = bus.wb_valid && bus.wb_dest == 3'(r);
    assign dec_ld[r] = dec[r] && bus.wb_is_load;

    decode_issue_ctr #(.CNT_W(CNT_W)) u_pend (
      .clk(clk), .rst_n(rst_n), .inc_i(inc[r]), .dec_i(dec[r]), .cnt_o(pend[r]));
    decode_issue_ctr #(.CNT_W(CNT_W)) u_ldp (
      .clk(clk), .rst_n(rst_n), .inc_i(inc_ld[r]), .dec_i(dec_ld[r]), .cnt_o(ldp[r]));

    a_ldp_le_pend: assert property (@(posedge clk) disable iff (!rst_n) ldp[r] <= pend[r]);
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_intr      = out_q.intr;
  assign bus.out_pc        = out_q.pc;
  assign bus.out_brpredict = out_q.bp;
  assign bus.out_sr1       = out_q.sr1;
  assign bus.out_sr2       = out_q.sr2;
  assign bus.out_dest      = out_q.dest;
  assign bus.out_is_load   = out_q.is_load;
  assign bus.stall_cnt     = stall_q;
endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: stimulus pushes expected issue fields into a
// queue, a negedge monitor compares them whenever the issue register is valid.
`timescale 1ns/1ps
module tb_decode_issue;
  typedef struct packed {
    logic [15:0] intr;
    logic [15:0] pc;
    logic        bp;
    logic [3:0]  sr1;
    logic [3:0]  sr2;
    logic [3:0]  dest;
    logic        ld;
  } exp_t;

`ifdef DECODE_FWD_EN
  localparam int T1_ST = 0;
`else
  localparam int T1_ST = 5;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   nvec = 0;
  int   nmis = 0;
  int   exp_stall = 0;
  exp_t q[$];

  decode_issue_if #(.PC_W(16), .PERF_W(16)) bus ();
  decode_issue #(.PC_W(16), .CNT_W(2), .PERF_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] intr, input logic [15:0] pc, input logic bp,
                              input logic [3:0] s1, input logic [3:0] s2,
                              input logic [3:0] d, input logic ld);
    return '{intr: intr, pc: pc, bp: bp, sr1: s1, sr2: s2, dest: d, ld: ld};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one instruction; st returns the number of cycles in_ready was low.
  task automatic send(input exp_t v, output int st);
    bus.in_valid     = 1'b1;
    bus.in_intr      = v.intr;
    bus.in_pc        = v.pc;
    bus.in_brpredict = v.bp;
    st = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      st++;
    end
    if (bus.in_ready) q.push_back(v);
    else begin
      nvec++; nmis++;
      $display("FAIL accept_timeout: intr %h never accepted", v.intr);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wb(input logic [2:0] d, input logic ld);
    bus.wb_valid   = 1'b1;
    bus.wb_dest    = d;
    bus.wb_is_load = ld;
    tick();
    bus.wb_valid   = 1'b0;
    bus.wb_is_load = 1'b0;
  endtask

  // Monitor: the front entry must match for as long as the issue register holds it.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (q.size() == 0) begin
        nvec++; nmis++;
        $display("FAIL unexpected_issue: got intr %h with empty scoreboard", bus.out_intr);
      end else begin
        exp_t got;
        got = '{bus.out_intr, bus.out_pc, bus.out_brpredict, bus.out_sr1,
                bus.out_sr2, bus.out_dest, bus.out_is_load};
        chk("issue_fields", 64'(got), 64'(q[0]));
        if (bus.out_ready || bus.flush) void'(q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int st;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_intr = '0; bus.in_pc = '0; bus.in_brpredict = 1'b0;
    bus.out_ready = 1'b1; bus.wb_valid = 1'b0; bus.wb_dest = '0; bus.wb_is_load = 1'b0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sr1", bus.out_sr1, 4'h8);
    chk("rst_out_sr2", bus.out_sr2, 4'h8);
    chk("rst_out_dest", bus.out_dest, 4'h8);
    chk("rst_out_intr", bus.out_intr, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_out_is_load", bus.out_is_load, 0);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", bus.in_ready, 1);

    // ADD R1,R2,R3 then ADD R4,R1,R1; wb of R1 four cycles after fire
    send(mk(16'h1283, 16'h3000, 1'b0, 4'h2, 4'h3, 4'h1, 1'b0), st);
    chk("t1_first_stalls", st, 0);
    fork
      send(mk(16'h1841, 16'h3002, 1'b0, 4'h1, 4'h1, 4'h4, 1'b0), st);
      begin repeat (4) tick(); wb(3'd1, 1'b0); end
    join
    chk("t1_raw_stalls", st, T1_ST);
    exp_stall += T1_ST;
    tick();
    chk("t1_stall_cnt", bus.stall_cnt, exp_stall);
    wb(3'd4, 1'b0);

    // LDR R2,R0,#1 then ADD R3,R2,R2: load-use stall in either build
    send(mk(16'h6401, 16'h3010, 1'b0, 4'h0, 4'h8, 4'h2, 1'b1), st);
    chk("t2_ldr_stalls", st, 0);
    fork
      send(mk(16'h1682, 16'h3012, 1'b0, 4'h2, 4'h2, 4'h3, 1'b0), st);
      begin repeat (4) tick(); wb(3'd2, 1'b1); end
    join
    chk("t2_load_use_stalls", st, 5);
    exp_stall += 5;
    tick();
    chk("t2_stall_cnt", bus.stall_cnt, exp_stall);
    wb(3'd3, 1'b0);

    // three writers of R5 fill the counter; a fourth waits for one wb
    for (int i = 0; i < 3; i++) begin
      send(mk(16'h1A21, 16'(16'h3020 + 2 * i), 1'(i == 1), 4'h0, 4'h8, 4'h5, 1'b0), st);
      chk("t3_writer_stalls", st, 0);
    end
    repeat (2) tick();
    fork
      send(mk(16'h1A21, 16'h3026, 1'b0, 4'h0, 4'h8, 4'h5, 1'b0), st);
      begin repeat (3) tick(); wb(3'd5, 1'b0); end
    join
    chk("t3_sat_stalls", st, 4);
    exp_stall += 4;
    tick();
    chk("t3_stall_cnt", bus.stall_cnt, exp_stall);
    repeat (3) wb(3'd5, 1'b0);

    // out_ready low for three cycles: STR held stable, JMP refused, no hazard stalls
    bus.out_ready = 1'b0;
    send(mk(16'h7702, 16'h3030, 1'b0, 4'h4, 4'h3, 4'h8, 1'b0), st);
    chk("t4_str_stalls", st, 0);
    fork
      send(mk(16'hC080, 16'h3032, 1'b1, 4'h2, 4'h8, 4'h8, 1'b0), st);
      begin repeat (3) tick(); bus.out_ready = 1'b1; end
    join
    chk("t4_backpressure_cycles", st, 3);
    chk("t4_stall_cnt", bus.stall_cnt, exp_stall);
    tick();

    // flush kills NOT R6 in the issue register; reader of R6 then issues freely
    bus.out_ready = 1'b0;
    send(mk(16'h9C7F, 16'h3040, 1'b0, 4'h1, 4'h8, 4'h6, 1'b0), st);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    fork
      send(mk(16'h1186, 16'h3042, 1'b0, 4'h6, 4'h6, 4'h0, 1'b0), st);
      begin
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("t5_flushed_valid", bus.out_valid, 0);
      end
    join
    chk("t5_flush_cycles", st, 1);
    chk("t5_stall_cnt", bus.stall_cnt, exp_stall);
    tick();
    wb(3'd0, 1'b0);

    // TRAP fires on the same edge as a wb to R7 while pend[7]=1
    send(mk(16'h4805, 16'h3050, 1'b1, 4'h8, 4'h8, 4'h7, 1'b0), st);
    chk("t6_jsr_stalls", st, 0);
    send(mk(16'hF025, 16'h3052, 1'b0, 4'h8, 4'h8, 4'h7, 1'b0), st);
    chk("t6_trap_stalls", st, 0);
    wb(3'd7, 1'b0);
    fork
      send(mk(16'h11E0, 16'h3054, 1'b0, 4'h7, 4'h8, 4'h0, 1'b0), st);
      begin repeat (3) tick(); wb(3'd7, 1'b0); end
    join
    chk("t6_pend7_stalls", st, 4);
    exp_stall += 4;
    tick();
    chk("t6_stall_cnt", bus.stall_cnt, exp_stall);
    wb(3'd0, 1'b0);
    chk("scoreboard_empty", q.size(), 0);

    // asynchronous reset while an instruction is held
    bus.out_ready = 1'b0;
    send(mk(16'h1283, 16'h3060, 1'b1, 4'h2, 4'h3, 4'h1, 1'b0), st);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_dest", bus.out_dest, 4'h8);
    chk("arst_out_bp", bus.out_brpredict, 0);
    chk("arst_stall_cnt", bus.stall_cnt, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_in_ready", bus.in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/decode_issue.md
# decode_issue

Parametrised LC-3b decode/issue stage with a register scoreboard. It sits between the IF/ID register and execute. It takes one fetched instruction per valid/ready handshake and extracts source and destination register indices and load/store class. It holds the instruction while a read-after-write hazard exists against any in-flight writer, then hands it to execute through a registered valid/ready output.

## Interface
- `PC_W`, 16, width of the PC field carried with the instruction.
- `CNT_W`, 2, width of each per-register outstanding-write counter; at most 2^CNT_W−1 writes in flight per register.
- `PERF_W`, 16, width of the saturating hazard-stall counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  IF/ID holds a valid instruction.
- `in_ready`  out  1  decode accepts the instruction this cycle.
- `in_intr`  in  16  instruction word.
- `in_pc`  in  PC_W  PC of the instruction.
- `in_brpredict`  in  1  fetch branch prediction bit.
- `out_valid`  out  1  issue register holds an instruction.
- `out_ready`  in  1  execute accepts the issue register.
- `out_intr`, `out_pc`, `out_brpredict`  out  16/PC_W/1  registered copies.
- `out_sr1`, `out_sr2`, `out_dest`  out  4 each  register index; bit 3 set means "none" (4'b1000).
- `out_is_load`  out  1  the instruction is LDR, LDB or LDI.
- `wb_valid`  in  1  a destination write has retired or been squashed.
- `wb_dest`  in  3  register written.
- `wb_is_load`  in  1  the retiring writer was a load.
- `flush`  in  1  kill the instruction in the issue register and refuse input this cycle.
- `stall_cnt`  out  PERF_W  cycles lost to hazards, saturating.

## Operation
- Decode field rules:
  - sr1 = intr[8:6] for ADD, AND, NOT, LDR, LDB, LDI, STR, STB, STI, JMP, SHF, and JSRR (intr[11]=0).
  - sr2 = intr[2:0] for ADD/AND with intr[5]=0; sr2 = intr[11:9] for STR, STB, STI.
  - dest = intr[11:9] for ADD, AND, NOT, LDR, LDB, LDI, LEA, SHF; dest = 7 for JSR, JSRR, TRAP.
  - Every other field is "none". BR, JMP and stores have no dest.
- Scoreboard state:
  - `pend[r]`, CNT_W bits: outstanding writes to register r.
  - `ldp[r]`, CNT_W bits: outstanding load writes to r.
- Hazard: a decoded source r (not "none") is hazardous when either holds:
  - pend[r]≠0 (see Configuration for the forwarding variant), or
  - out_valid and out_dest==r.
  - Also stall when the decoded dest d has pend[d] at its maximum value.
- `in_ready` = !flush & !hazard & (!out_valid | out_ready).
- Accept (in_valid & in_ready): load the issue register; out_valid←1.
- Fire (out_valid & out_ready & !flush):
  - if out_dest valid: pend[out_dest]++, and ldp[out_dest]++ when out_is_load.
  - out_valid←0 unless an accept happens in the same cycle.
- wb_valid: pend[wb_dest]--, and ldp[wb_dest]-- when wb_is_load. Execute returns exactly one wb for every fired instruction that has a dest, including squashed ones.
- Fire and wb on the same register in the same cycle: the counter is unchanged.
- Flush: out_valid←0 with no scoreboard change; input is not accepted that cycle.
- `stall_cnt` increments in every cycle with in_valid & hazard & !flush, and holds at all-ones.
- Error cases (unreachable in a correct system): wb to a counter at 0, or fire to a saturated counter. Both leave the counter unchanged; simulation asserts flag them.

## Timing
- Reset: out_valid=0, every pend/ldp=0, stall_cnt=0, remaining out_* = 0, with out_sr1/out_sr2/out_dest = 4'b1000.
- Latency: accept to out_valid is 1 cycle. Back-to-back accepts run at 1 per cycle when there are no hazards and out_ready=1.
- The hazard check reads the registered counters, so a wb releases a stalled consumer in the cycle after wb_valid.
- The output holds stable while out_valid & !out_ready.
- rst_n asserted mid-operation clears all state asynchronously; in-flight wbs after reset are ignored, which needs downstream reset to be simultaneous.

## Configuration
- `DECODE_FWD_EN` defined: execute forwards ALU results, so the pend[r] term of the hazard becomes ldp[r]≠0 (load-use only). The out_dest term becomes out_valid & out_is_load & out_dest==r.
- `DECODE_FWD_EN` undefined: any outstanding writer stalls, as specified in Operation.

## Test plan
- ADD R1,R2,R3 then ADD R4,R1,R1 with wb of R1 four cycles after fire:
  - without FWD, the second instruction's in_ready stays 0 until the cycle after wb; stall_cnt increases by the number of stalled cycles.
  - with FWD, there is no stall.
- LDR R2,R0,#1 then ADD R3,R2,R2 with DECODE_FWD_EN: stall until the cycle after wb_valid & wb_is_load & wb_dest=2; the ADD then issues.
- Three consecutive ADDs writing R5 with no wb (CNT_W=2): the third fires; a fourth writer of R5 stalls until one wb arrives.
- out_ready=0 for 3 cycles with an instruction held: out_* stays stable, in_ready=0, no counter changes.
- Flush with out_valid=1 holding dest R6: out_valid→0, pend[6] stays 0, and a following reader of R6 issues with no stall.
- Fire of dest R7 (TRAP) in the same cycle as a wb to R7 with pend[7]=1: pend[7] stays 1.
